addsub_seq: RTL and testbench
=============================

Name: addsub_seq

Overview:
- Parametrised, multi-cycle adder/subtractor. It replaces the fixed 8-bit combinational add path.
- Each cycle it processes CHUNK bits of a WIDTH-bit operand pair, carrying between chunks in a register.
- It adds a subtract mode, status flags (carry/no-borrow, signed overflow, zero) and valid/ready handshakes on both sides.
- It sits between operand registers and the result consumer in the arithmetic datapath, where area matters more than throughput.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2.
- CHUNK, 2, bits processed per cycle; must divide WIDTH exactly. Elaboration error otherwise.
- NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- sub  input  1  0 = a+b, 1 = a−b; sampled with the operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts the result
- res  output  WIDTH  result, modulo 2^WIDTH
- co  output  1  final carry-out; for sub, 1 = no borrow (a ≥ b unsigned)
- ov  output  1  two's-complement overflow
- z  output  1  res == 0

Behaviour:
- Reset (rst_n=0, async): state=IDLE; res, co, ov, z, out_valid=0; in_ready=1; internal count, carry and operand registers=0.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch a into opa and (sub ? ~b : b) into opb, set carry=sub and count=0, then go to RUN.
  - All other inputs are ignored.
- RUN:
  - in_ready=0. Each cycle, sum CHUNK bits of opa/opb at slice [count*CHUNK +: CHUNK] plus carry.
  - Write the sum into the same res slice and register the chunk carry-out into carry.
  - On the last chunk (count==NCHUNK−1), also capture the carry into the MSB. On that edge set co=carry-out, ov=carry-into-MSB XOR carry-out, z=(final res==0), out_valid=1, and go to DONE. Otherwise count++.
- Latency: out_valid rises exactly NCHUNK clock edges after the accepting edge (NCHUNK=1 → the next cycle).
- DONE:
  - out_valid=1, in_ready=0.
  - res/co/ov/z are held stable until an edge with out_ready=1; then out_valid=0 and state returns to IDLE.
  - in_valid during DONE is ignored; no pass-through.
- Throughput: one operation per NCHUNK+2 cycles at most (accept, NCHUNK runs, drain). in_ready and out_valid are never both 1.
- res bits not yet written in RUN hold their previous values. Consumers use res only while out_valid=1.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the in-flight operation is discarded and no partial result is flagged.
- Overflow rules:
  - add: ov=1 iff both operands have the same sign and res has the opposite sign.
  - sub: ov=1 iff a and b differ in sign and res's sign differs from a.
- state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2. Illegal 2'd3 → IDLE next cycle with out_valid=0.

Decomposition:
- Shared package arith_pkg holds:
  - the state typedef (IDLE/RUN/DONE)
  - the SUB/ADD mode constants
  - a width-check function for WIDTH%CHUNK.
- One natural sub-module: sum_chunk, a combinational CHUNK-bit ripple adder chained from the team's 1-bit full-adder cell sum. It outputs the chunk sum, carry-out and carry-into-MSB.
- addsub_seq contains the FSM, counter, operand/result registers and flag logic.

Test Plan:
- WIDTH=8, CHUNK=2, add 0x35+0x4A, out_ready=1 → out_valid exactly 4 edges after accept; res=0x7F, co=0, ov=0, z=0; in_ready back to 1 the cycle after the drain.
- add 0xFF+0x01 → res=0x00, co=1, ov=0, z=1. Then add 0x7F+0x01 → res=0x80, co=0, ov=1.
- sub 0x80−0x01 → res=0x7F, co=1, ov=1. Then sub 0x05−0x07 → res=0xFE, co=0, ov=0, z=0.
- Backpressure: out_ready=0 for 3 cycles after out_valid, with in_valid=1 carrying a=0x11, b=0x22 → res/flags stable, in_ready=0, new operands not taken; after out_ready=1, the next accept takes the then-present operands.
- Reset at the 2nd RUN cycle → outputs zero at once, in_ready=1, no out_valid. A fresh add 0x10+0x20 completes with res=0x30.
- Parameter sweep: (WIDTH=16, CHUNK=1) latency 16 and (WIDTH=16, CHUNK=16) latency 1. Random 1000 ops per config, checked against a reference model for res/co/ov/z.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding, add/sub mode values and
// an elaboration-time parameter sanity check.
package arith_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic bit width_ok(input int width, input int chunk);
    return (width >= 2) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder cell.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/sum_chunk.sv
// Combinational CHUNK-bit ripple adder built from fa_cell; also exposes the
// carry into its top bit so the caller can derive signed overflow.
module sum_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    fa_cell u_fa (
      .i_a  (i_a[g]),
      .i_b  (i_b[g]),
      .i_c  (w_c[g]),
      .o_s  (o_sum[g]),
      .o_co (w_c[g+1])
    );
  end

  assign o_cout = w_c[CHUNK];
  assign o_cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, result after WIDTH/CHUNK
// cycles, held in DONE until out_ready. Subtraction is a + ~b + 1.
module addsub_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             co,
  output logic             ov,
  output logic             z
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_params
    $error("addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_co;
  logic             r_ov;
  logic             r_z;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Constant-index slice selection keeps the mux free of variable part-selects.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_chunk = r_opa[k*CHUNK +: CHUNK];
        w_b_chunk = r_opb[k*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    w_res_next = r_res;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_cnt == CW'(k)) begin
        w_res_next[k*CHUNK +: CHUNK] = w_sum;
      end
    end
  end

  assign w_last = (r_cnt == CW'(NCHUNK - 1));

  sum_chunk #(.CHUNK(CHUNK)) u_sum (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_opa   <= a;
            r_opb   <= (sub == MODE_SUB) ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          if (w_last) begin
            r_co    <= w_cout;
            r_ov    <= w_cmsb ^ w_cout;
            r_z     <= (w_res_next == '0);
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign res       = r_res;
  assign co        = r_co;
  assign ov        = r_ov;
  assign z         = r_z;

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench: 8/2 directed vectors plus 16/1 and 16/16 sweeps against a reference model.
module tb_addsub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, sub, out_valid, out_ready, co, ov, z;
  logic [7:0] a, b, res;

  addsub_seq #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .co(co), .ov(ov), .z(z)
  );

  logic        s_iv[2], s_ir[2], s_sub[2], s_ovld[2], s_ordy[2], s_co[2], s_ov[2], s_z[2];
  logic [15:0] s_a[2], s_b[2], s_res[2];

  addsub_seq #(.WIDTH(16), .CHUNK(1)) u_w16c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv[0]), .in_ready(s_ir[0]), .sub(s_sub[0]),
    .a(s_a[0]), .b(s_b[0]), .out_valid(s_ovld[0]), .out_ready(s_ordy[0]), .res(s_res[0]),
    .co(s_co[0]), .ov(s_ov[0]), .z(s_z[0])
  );

  addsub_seq #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv[1]), .in_ready(s_ir[1]), .sub(s_sub[1]),
    .a(s_a[1]), .b(s_b[1]), .out_valid(s_ovld[1]), .out_ready(s_ordy[1]), .res(s_res[1]),
    .co(s_co[1]), .ov(s_ov[1]), .z(s_z[1])
  );

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        ov;
    logic        z;
    int          acc;
    int          idx;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sampled on the falling edge; out_ready only changes just after a rising edge,
  // so valid && ready seen here is the handshake taken on the next rising edge.
  logic prev8 = 1'b0;
  always @(negedge clk) begin : mon8
    exp_t e;
    check("excl8", 32'(in_ready & out_valid), 32'd0);
    if (out_valid === 1'b1) begin
      if (q8.size() == 0) begin
        check("unexpected_out8", 32'd1, 32'd0);
      end else begin
        e = q8[0];
        check("res8", 32'(res), 32'(e.res[7:0]));
        check("co8",  32'(co),  32'(e.co));
        check("ov8",  32'(ov),  32'(e.ov));
        check("z8",   32'(z),   32'(e.z));
        if (!prev8) check("latency8", 32'(cyc - e.acc), 32'd4);
        if (out_ready) void'(q8.pop_front());
      end
    end
    prev8 <= out_valid;
  end

  logic prev16[2] = '{1'b0, 1'b0};
  always @(negedge clk) begin : mon16
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      check("excl16", 32'(s_ir[k] & s_ovld[k]), 32'd0);
      if (s_ovld[k] === 1'b1) begin
        if (q16.size() == 0 || q16[0].idx != k) begin
          check("unexpected_out16", 32'd1, 32'd0);
        end else begin
          e = q16[0];
          check("res16", 32'(s_res[k]), 32'(e.res));
          check("co16",  32'(s_co[k]),  32'(e.co));
          check("ov16",  32'(s_ov[k]),  32'(e.ov));
          check("z16",   32'(s_z[k]),   32'(e.z));
          if (!prev16[k]) check("latency16", 32'(cyc - e.acc), (k == 0) ? 32'd16 : 32'd1);
          if (s_ordy[k]) void'(q16.pop_front());
        end
      end
      prev16[k] <= s_ovld[k];
    end
  end

  task automatic issue8(input logic s, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] er, input logic eco, input logic eov,
                        input logic ez, input bit push);
    exp_t e;
    int   g = 0;
    @(negedge clk);
    in_valid = 1'b1; sub = s; a = ia; b = ib;
    while (in_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("accept_timeout8", 32'd0, 32'd1);
    e.res = 16'(er); e.co = eco; e.ov = eov; e.z = ez; e.acc = cyc + 1; e.idx = 0;
    if (push) q8.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain8();
    int g = 0;
    while (q8.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (g >= 200) check("drain_timeout8", 32'd0, 32'd1);
  endtask

  task automatic issue16(input int k, input logic s, input logic [15:0] ia, input logic [15:0] ib);
    exp_t        e;
    logic [16:0] t;
    logic [15:0] bb;
    int          g = 0;
    bb = s ? ~ib : ib;
    t  = {1'b0, ia} + {1'b0, bb} + 17'(s);
    e.res = t[15:0];
    e.co  = t[16];
    e.ov  = s ? ((ia[15] != ib[15]) && (t[15] != ia[15]))
              : ((ia[15] == ib[15]) && (t[15] != ia[15]));
    e.z   = (t[15:0] == 16'd0);
    e.idx = k;
    @(negedge clk);
    s_iv[k] = 1'b1; s_sub[k] = s; s_a[k] = ia; s_b[k] = ib;
    while (s_ir[k] !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("accept_timeout16", 32'd0, 32'd1);
    e.acc = cyc + 1;
    q16.push_back(e);
    @(negedge clk);
    s_iv[k] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; a = '0; b = '0;
    for (int k = 0; k < 2; k++) begin
      s_iv[k] = 1'b0; s_sub[k] = 1'b0; s_a[k] = '0; s_b[k] = '0; s_ordy[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res",       32'(res),       32'd0);
    check("rst_flags",     32'({co, ov, z}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    issue8(1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    drain8();
    @(negedge clk);
    check("in_ready_after_drain", 32'(in_ready), 32'd1);

    issue8(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    issue8(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    issue8(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
    issue8(1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    issue8(1'b1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    issue8(1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    issue8(1'b1, 8'h00, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    drain8();

    // Backpressure: result must hold while new operands wait at the input.
    @(posedge clk); #1 out_ready = 1'b0;
    issue8(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);
    g = 0;
    while (out_valid !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("bp_valid_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; sub = 1'b0; a = 8'h11; b = 8'h22;
    repeat (3) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    issue8(1'b0, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    drain8();

    // Reset during the second RUN cycle discards the operation.
    issue8(1'b0, 8'h55, 8'h11, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_res",       32'(res),       32'd0);
    check("mid_rst_flags",     32'({co, ov, z}), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue8(1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);
    drain8();

    for (int k = 0; k < 2; k++) begin
      issue16(k, 1'b0, 16'hFFFF, 16'h0001);
      issue16(k, 1'b0, 16'h7FFF, 16'h0001);
      issue16(k, 1'b1, 16'h8000, 16'h0001);
      issue16(k, 1'b1, 16'h1234, 16'h1234);
      issue16(k, 1'b1, 16'h0000, 16'h0001);
      for (int i = 0; i < 1000; i++) begin
        issue16(k, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end
      g = 0;
      while (q16.size() != 0 && g < 200) begin
        @(posedge clk);
        g++;
      end
      if (g >= 200) check("drain_timeout16", 32'd0, 32'd1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
